pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage core; it generalises the IF/ID latch into a reusable stage boundary for IF/ID, ID/EX, EX/MEM and MEM/WB. It carries LANES parallel PC/instruction slots with per-lane valid bits. It implements the shared six-bit stall-vector protocol (hold, bubble, advance) plus whole-stage flush and per-lane kill. An optional perf block counts bubble and hold cycles.

## Interface
- PC_W, 32, width of each lane's PC field
- INST_W, 32, width of each lane's instruction/payload field
- LANES, 1, number of parallel issue slots (1..4); lane 0 occupies the LSBs of every packed bus
- STAGE, 1, index of the upstream stage's bit in stall_i; STAGE+1 is the downstream bit
- STALL_W, 6, width of the stall vector
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall_i  in  STALL_W  pipeline stall vector from the stall controller
- flush_i  in  1  kill all lanes (exception/redirect)
- kill_i  in  LANES  per-lane kill of the incoming slot
- in_valid  in  LANES  upstream lane valid
- in_pc  in  LANES*PC_W  upstream PCs
- in_inst  in  LANES*INST_W  upstream payloads
- out_valid  out  LANES  registered lane valid
- out_pc  out  LANES*PC_W  registered PCs
- out_inst  out  LANES*INST_W  registered payloads
- bubble_cnt  out  32  bubble cycles, present only with PIPE_STAGE_PERF_EN
- hold_cnt  out  32  hold cycles, present only with PIPE_STAGE_PERF_EN

## Operation
- up = stall_i[STAGE]. dn = stall_i[STAGE+1], forced to 0 when STAGE == STALL_W-1.
- Per-edge priority, highest first:
  - rst: all outputs 0.
  - flush_i: all lanes out_valid=0; out_pc and out_inst zeroed, regardless of stall.
  - BUBBLE (up=1, dn=0): all lanes out_valid=0, payload zeroed.
  - ADVANCE (up=0): lane i captures in_pc/in_inst; out_valid[i] = in_valid[i] & ~kill_i[i].
  - HOLD (up=1, dn=1): all registers unchanged.
- Zeroed-lane invariant: a lane leaving with out_valid=0 carries all-zero PC and payload (all-zero word = NOP). This applies on advance too: an invalid or killed incoming lane is stored as zeros.
- kill_i only acts on ADVANCE. It is ignored on HOLD and BUBBLE.
- Stall vector is assumed well-formed (up=0 with dn=1 never occurs). If it does, ADVANCE applies.

## Timing
- Latency 1 cycle, input to output on ADVANCE; no combinational input-to-output path.
- Reset value of every output is 0, including counters; reset held for N cycles gives 0 for those N edges.
- flush_i asserted together with rst: reset wins (same visible result).
- flush_i in the same cycle as ADVANCE: flush wins and the incoming data is discarded.
- HOLD keeps outputs bit-stable for any number of cycles. The first ADVANCE after HOLD loads the current inputs, not the inputs from when the stall began.

## Configuration
- PIPE_STAGE_PERF_EN defined:
  - bubble_cnt increments on every BUBBLE edge.
  - hold_cnt increments on every HOLD edge.
  - Both are 32-bit and saturate at 0xFFFF_FFFF, with no wrap.
  - Neither counter increments on a flush or reset edge; rst clears both.
- PIPE_STAGE_PERF_EN undefined: counter ports and logic are absent; all other behaviour is identical.

## Structure
- Shared package pipe_pkg holds:
  - stall-vector bit indices (STALL_PC=0, STALL_IF=1, STALL_ID=2, STALL_EX=3, STALL_MEM=4, STALL_WB=5)
  - STALL_W=6
  - NOP_INST=0
  - the stage-action encoding (ACT_HOLD, ACT_BUBBLE, ACT_ADVANCE, ACT_FLUSH)
- Parent decodes the action once and drives sub-module pipe_lane_reg, instantiated LANES times.
- pipe_lane_reg is one lane's valid/pc/inst registers with the action and kill inputs.
- Perf counters live in the parent.

## Test plan
- Reset: rst=1 for 2 cycles with nonzero inputs -> out_valid=0, out_pc=0, out_inst=0. With perf enabled, counters=0.
- Advance: STAGE=1, stall_i=6'b000000, in_pc=0x0040_0010, in_inst=0x2408_0005, in_valid=1 -> next edge shows the same values with out_valid=1.
- Bubble then hold:
  - stall_i=6'b000011 -> zeros with out_valid=0, bubble_cnt=1.
  - Load 0x0040_0020, then stall_i=6'b000111 for 3 cycles -> 0x0040_0020 held, hold_cnt=3.
- Flush over hold: stall_i=6'b000111 with flush_i=1 -> out_valid=0 and zeroed payload next edge, hold_cnt not incremented.
- Dual lane kill: LANES=2, in_valid=2'b11, kill_i=2'b10 on advance -> out_valid=2'b01, lane 1 PC and inst equal 0, lane 0 data intact.
- Counter saturation: preload hold_cnt to 0xFFFF_FFFE via force, then 3 hold cycles -> hold_cnt=0xFFFF_FFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the five-stage core's pipeline plumbing:
// stall-vector bit positions, the NOP encoding and the per-edge
// stage action that every stage boundary register obeys.
package pipe_pkg;

  // Bit positions inside the stall vector driven by the stall controller.
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;
  localparam int STALL_W   = 6;

  // All-zero word is the architectural NOP carried by dead slots.
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // What a stage boundary does on the coming clock edge.
  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_ADVANCE = 2'd2,
    ACT_FLUSH   = 2'd3
  } stage_act_e;

  // Flush beats everything; a stalled upstream with a free downstream
  // inserts a bubble; a free upstream always advances (this also covers
  // the malformed up=0/dn=1 case); both stalled means hold.
  function automatic stage_act_e decode_act(input logic flush,
                                            input logic up,
                                            input logic dn);
    if (flush)          return ACT_FLUSH;
    else if (!up)       return ACT_ADVANCE;
    else if (!dn)       return ACT_BUBBLE;
    else                return ACT_HOLD;
  endfunction

endpackage

// File: rtl/pipe_lane_reg.sv
// One issue slot of a stage boundary: valid, PC and payload registers.
// The parent decodes the stage action once and fans it out to every lane;
// the lane only adds its own kill and the zeroed-dead-slot rule.
module pipe_lane_reg
  import pipe_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  stage_act_e        act_i,
  input  logic              kill_i,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst
);

  logic              valid_d, valid_q;
  logic [PC_W-1:0]   pc_d,    pc_q;
  logic [INST_W-1:0] inst_d,  inst_q;
  logic              keep;

  // Next-state selection for the slot according to the stage action.
  always_comb begin
    // NOTE: every always_comb output gets a default first (here: hold), so
    // no path through the case can leave a variable unassigned and infer a latch.
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    keep    = in_valid & ~kill_i;
    case (act_i)
      ACT_FLUSH, ACT_BUBBLE: begin
        valid_d = 1'b0;
        pc_d    = '0;
        inst_d  = INST_W'(NOP_INST);
      end
      ACT_ADVANCE: begin
        // Dead slots are stored as zeros so downstream sees a clean NOP.
        valid_d = keep;
        pc_d    = keep ? in_pc   : '0;
        inst_d  = keep ? in_inst : INST_W'(NOP_INST);
      end
      default: ;
    endcase
  end

  // Slot registers with the core's synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops sample
    // their _d values from before the edge, independent of statement order.
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_inst  = inst_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) carrying
// LANES PC/payload slots. Obeys the shared stall vector (hold, bubble,
// advance), whole-stage flush and per-lane kill.
// Optional feature macro: PIPE_STAGE_PERF_EN adds saturating 32-bit
// bubble_cnt / hold_cnt performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int INST_W  = 32,
  parameter int LANES   = 1,
  parameter int STAGE   = 1,
  parameter int STALL_W = pipe_pkg::STALL_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall_i,
  input  logic                    flush_i,
  input  logic [LANES-1:0]        kill_i,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES*PC_W-1:0]   in_pc,
  input  logic [LANES*INST_W-1:0] in_inst,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*PC_W-1:0]   out_pc,
  output logic [LANES*INST_W-1:0] out_inst
`ifdef PIPE_STAGE_PERF_EN
  , output logic [31:0]           bubble_cnt
  , output logic [31:0]           hold_cnt
`endif
);

  // The last stage has no downstream stall bit; treat it as never stalled.
  localparam bit HAS_DN = (STAGE < STALL_W - 1);
  localparam int DN_IDX = HAS_DN ? STAGE + 1 : STAGE;

  logic       up;
  logic       dn;
  logic       stall_unused;
  stage_act_e act;

  assign up           = stall_i[STAGE];
  assign dn           = HAS_DN ? stall_i[DN_IDX] : 1'b0;
  assign stall_unused = ^stall_i;

  // Decode the stage action once for all lanes.
  always_comb act = decode_act(flush_i, up, dn);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pipe_lane_reg #(
      .PC_W   (PC_W),
      .INST_W (INST_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .act_i     (act),
      .kill_i    (kill_i[i]),
      .in_valid  (in_valid[i]),
      .in_pc     (in_pc[i*PC_W +: PC_W]),
      .in_inst   (in_inst[i*INST_W +: INST_W]),
      .out_valid (out_valid[i]),
      .out_pc    (out_pc[i*PC_W +: PC_W]),
      .out_inst  (out_inst[i*INST_W +: INST_W])
    );
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] bubble_cnt_d, bubble_cnt_q;
  logic [31:0] hold_cnt_d,   hold_cnt_q;

  // Saturating event counts; flush edges count as neither bubble nor hold.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    if (act == ACT_BUBBLE && bubble_cnt_q != 32'hFFFF_FFFF)
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    if (act == ACT_HOLD && hold_cnt_q != 32'hFFFF_FFFF)
      hold_cnt_d = hold_cnt_q + 32'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign hold_cnt   = hold_cnt_q;
`else
  // Counters not built: no ports, no state.
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (LANES=2, STAGE=1).
// Directed steps follow the stage-boundary rules, then a randomized run;
// every observation is compared against a lane-array reference model.
// Counter checks are compiled in when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

  localparam int PC_W    = 32;
  localparam int INST_W  = 32;
  localparam int LANES   = 2;
  localparam int STAGE   = 1;
  localparam int STALL_W = 6;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [STALL_W-1:0]      stall_i;
  logic                    flush_i;
  logic [LANES-1:0]        kill_i;
  logic [LANES-1:0]        in_valid;
  logic [LANES*PC_W-1:0]   in_pc;
  logic [LANES*INST_W-1:0] in_inst;
  logic [LANES-1:0]        out_valid;
  logic [LANES*PC_W-1:0]   out_pc;
  logic [LANES*INST_W-1:0] out_inst;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]             bubble_cnt;
  logic [31:0]             hold_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: what each slot should hold after the next edge.
  logic        m_valid [LANES];
  logic [31:0] m_pc    [LANES];
  logic [31:0] m_inst  [LANES];
  logic [31:0] m_bubble;
  logic [31:0] m_hold;

  pipe_stage_reg #(
    .PC_W    (PC_W),
    .INST_W  (INST_W),
    .LANES   (LANES),
    .STAGE   (STAGE),
    .STALL_W (STALL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .kill_i    (kill_i),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst)
`ifdef PIPE_STAGE_PERF_EN
    , .bubble_cnt (bubble_cnt)
    , .hold_cnt   (hold_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Apply the stage rules to the model for the inputs currently driven.
  task automatic model_edge();
    logic up, dn;
    up = stall_i[STAGE];
    dn = stall_i[STAGE+1];
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        m_valid[i] = 1'b0; m_pc[i] = '0; m_inst[i] = '0;
      end
      m_bubble = '0;
      m_hold   = '0;
    end else if (flush_i || (up && !dn)) begin
      for (int i = 0; i < LANES; i++) begin
        m_valid[i] = 1'b0; m_pc[i] = '0; m_inst[i] = '0;
      end
      if (!flush_i) m_bubble = sat_inc(m_bubble);
    end else if (!up) begin
      for (int i = 0; i < LANES; i++) begin
        if (in_valid[i] && !kill_i[i]) begin
          m_valid[i] = 1'b1;
          m_pc[i]    = in_pc[i*PC_W +: PC_W];
          m_inst[i]  = in_inst[i*INST_W +: INST_W];
        end else begin
          m_valid[i] = 1'b0; m_pc[i] = '0; m_inst[i] = '0;
        end
      end
    end else begin
      m_hold = sat_inc(m_hold);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < LANES; i++) begin
      check($sformatf("%s.valid%0d", tag, i), {31'd0, out_valid[i]}, {31'd0, m_valid[i]});
      check($sformatf("%s.pc%0d", tag, i), out_pc[i*PC_W +: PC_W], m_pc[i]);
      check($sformatf("%s.inst%0d", tag, i), out_inst[i*INST_W +: INST_W], m_inst[i]);
    end
`ifdef PIPE_STAGE_PERF_EN
    check({tag, ".bubble_cnt"}, bubble_cnt, m_bubble);
    check({tag, ".hold_cnt"}, hold_cnt, m_hold);
`endif
  endtask

  // One clock: update the model, let the edge happen, observe 1 ns later.
  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [5:0] stall, input logic flush,
                       input logic [1:0] vld, input logic [1:0] kill,
                       input logic [31:0] pc0, input logic [31:0] inst0,
                       input logic [31:0] pc1, input logic [31:0] inst1);
    stall_i  = stall;
    flush_i  = flush;
    in_valid = vld;
    kill_i   = kill;
    in_pc    = {pc1, pc0};
    in_inst  = {inst1, inst0};
  endtask

  initial begin
    // Reset for two cycles with busy inputs and a simultaneous flush.
    rst = 1'b1;
    drive(6'b000000, 1'b1, 2'b11, 2'b00, 32'hDEAD_BEEF, 32'h1234_5678,
          32'hCAFE_F00D, 32'h8765_4321);
    tick("reset0");
    tick("reset1");
    rst = 1'b0;

    // Plain advance on lane 0.
    drive(6'b000000, 1'b0, 2'b01, 2'b00, 32'h0040_0010, 32'h2408_0005, 32'h0, 32'h0);
    tick("advance");

    // Bubble: upstream stalled, downstream free.
    drive(6'b000011, 1'b0, 2'b11, 2'b00, 32'h1111_1111, 32'h2222_2222,
          32'h3333_3333, 32'h4444_4444);
    tick("bubble");

    // Load 0x0040_0020 then hold three cycles while inputs churn.
    drive(6'b000000, 1'b0, 2'b01, 2'b00, 32'h0040_0020, 32'h2409_0007, 32'h0, 32'h0);
    tick("load");
    drive(6'b000111, 1'b0, 2'b11, 2'b11, 32'h5555_0000, 32'h6666_0000,
          32'h7777_0000, 32'h8888_0000);
    tick("hold0");
    in_pc = {32'h7777_0001, 32'h5555_0001};
    tick("hold1");
    in_valid = 2'b00;
    tick("hold2");

    // First advance after hold takes the current inputs.
    drive(6'b000000, 1'b0, 2'b11, 2'b00, 32'h0040_0030, 32'h0000_0AAA,
          32'h0040_0034, 32'h0000_0BBB);
    tick("post_hold");

    // Flush while the stall vector says hold.
    drive(6'b000111, 1'b1, 2'b11, 2'b00, 32'h0040_0040, 32'h1, 32'h0040_0044, 32'h2);
    tick("flush_hold");

    // Flush during advance discards incoming data.
    drive(6'b000000, 1'b1, 2'b11, 2'b00, 32'h0040_0050, 32'h3, 32'h0040_0054, 32'h4);
    tick("flush_adv");

    // Dual-lane kill of lane 1.
    drive(6'b000000, 1'b0, 2'b11, 2'b10, 32'h0040_0060, 32'h2408_0001,
          32'h0040_0064, 32'h2408_0002);
    tick("kill_l1");

    // Invalid lane carries zeros; malformed up=0/dn=1 still advances.
    drive(6'b000100, 1'b0, 2'b10, 2'b00, 32'h0040_0070, 32'h5,
          32'h0040_0074, 32'h6);
    tick("malformed");

`ifdef PIPE_STAGE_PERF_EN
    // Counter saturation: preload near the top, then hold three edges.
    force dut.hold_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.hold_cnt_q;
    m_hold = 32'hFFFF_FFFE;
    drive(6'b000111, 1'b0, 2'b11, 2'b00, 32'h9, 32'h9, 32'h9, 32'h9);
    tick("sat0");
    tick("sat1");
    tick("sat2");
`endif

    // Randomized run against the model.
    for (int n = 0; n < 300; n++) begin
      logic [5:0] st;
      case ($urandom_range(0, 3))
        0:       st = 6'b000000;
        1:       st = 6'b000011;
        2:       st = 6'b000111;
        default: st = 6'($urandom);
      endcase
      rst = ($urandom_range(0, 31) == 0);
      drive(st, ($urandom_range(0, 7) == 0), 2'($urandom), 2'($urandom),
            $urandom, $urandom, $urandom, $urandom);
      tick($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
